// File: rtl/rs_issue_sched.sv
// Issue scheduler / allocation controller for a small tagged reservation station.
// Allocates dispatched instructions to the lowest free entry, wakes operands from
// the result-tag broadcast, and issues the oldest ready entry through a one-deep
// output stage with a valid/ready handshake.
module rs_issue_sched #(
   parameter int unsigned ENTRIES     = 4,
   parameter int unsigned instr_width = 16,
   parameter int unsigned tag_width   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   input  logic [instr_width-1:0]     alloc_instr,
   input  logic [tag_width-1:0]       alloc_wb_tag,
   input  logic [tag_width-1:0]       alloc_tag0,
   input  logic [tag_width-1:0]       alloc_tag1,
   input  logic                       alloc_rdy0,
   input  logic                       alloc_rdy1,
   input  logic                       bcast_valid,
   input  logic [tag_width-1:0]       bcast_tag,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [instr_width-1:0]     issue_instr,
   output logic [tag_width-1:0]       issue_wb_tag,
   output logic [$clog2(ENTRIES)-1:0] issue_entry,
   output logic [ENTRIES-1:0]         entry_write,
   output logic [ENTRIES-1:0]         entry_read,
   output logic [$clog2(ENTRIES):0]   free_count
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned CNT_W = IDX_W + 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } st_e;

   typedef struct packed {
      st_e                    st;
      logic                   rdy0;
      logic                   rdy1;
      logic [tag_width-1:0]   tag0;
      logic [tag_width-1:0]   tag1;
      logic [tag_width-1:0]   wb_tag;
      logic [instr_width-1:0] instr;
   } entry_t;

   localparam entry_t ENTRY_RST = '{st: ST_EMPTY, default: '0};

   entry_t             ent_q [ENTRIES];
   entry_t             ent_d [ENTRIES];
   logic [ENTRIES-1:0] age_q [ENTRIES];
   logic [ENTRIES-1:0] age_d [ENTRIES];
   logic [CNT_W-1:0]   free_q;
   logic [CNT_W-1:0]   free_d;

   logic [ENTRIES-1:0] occ;
   logic [ENTRIES-1:0] rdy_v;
   logic [ENTRIES-1:0] cand;
   logic [IDX_W-1:0]   alloc_idx;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_any;
   logic               alloc_fire;
   logic               sel_fire;
   logic               byp0;
   logic               byp1;
   entry_t             sel_ent;

   // Occupancy and readiness views of the registered entry state
   always_comb begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
         occ[i]   = (ent_q[i].st != ST_EMPTY);
         rdy_v[i] = (ent_q[i].st == ST_READY);
      end
   end

   // Lowest-indexed empty entry receives the next allocation
   always_comb begin
      alloc_idx = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (!occ[i]) alloc_idx = IDX_W'(i);
      end
   end

   // Oldest ready entry: ready, with no ready entry marked older than it
   always_comb begin
      logic [ENTRIES-1:0] older;
      for (int i = 0; i < int'(ENTRIES); i++) begin
         for (int j = 0; j < int'(ENTRIES); j++) begin
            older[j] = rdy_v[j] & age_q[j][i];
         end
         cand[i] = rdy_v[i] & ~(|older);
      end
   end

   // Encode the candidate and fetch its fields for the output stage
   always_comb begin
      sel_idx = '0;
      sel_ent = ent_q[0];
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_idx = IDX_W'(i);
            sel_ent = ent_q[i];
         end
      end
   end

   assign sel_any     = |cand;
   assign alloc_ready = (free_q != '0);
   assign free_count  = free_q;
   assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
   assign sel_fire    = sel_any & (~issue_valid | issue_ready) & ~flush;
   assign byp0        = alloc_rdy0 | (bcast_valid & (bcast_tag == alloc_tag0));
   assign byp1        = alloc_rdy1 | (bcast_valid & (bcast_tag == alloc_tag1));

   // One-hot datapath strobes, same cycle as the allocation / selection
   always_comb begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
         entry_write[i] = alloc_fire & (alloc_idx == IDX_W'(i));
         entry_read[i]  = sel_fire & (sel_idx == IDX_W'(i));
      end
   end

   // Next entry state: wakeup, selection release, allocation and age update
   always_comb begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
         ent_d[i] = ent_q[i];
         age_d[i] = age_q[i];
      end
      free_d = free_q;
      if (flush) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ent_d[i].st = ST_EMPTY;
         end
         free_d = CNT_W'(ENTRIES);
      end else begin
         free_d = free_q - CNT_W'(alloc_fire) + CNT_W'(sel_fire);
         for (int i = 0; i < int'(ENTRIES); i++) begin
            if (ent_q[i].st == ST_WAIT) begin
               if (bcast_valid && (ent_q[i].tag0 == bcast_tag)) ent_d[i].rdy0 = 1'b1;
               if (bcast_valid && (ent_q[i].tag1 == bcast_tag)) ent_d[i].rdy1 = 1'b1;
               if (ent_d[i].rdy0 && ent_d[i].rdy1) ent_d[i].st = ST_READY;
            end
            if (entry_read[i]) ent_d[i].st = ST_EMPTY;
            if (entry_write[i]) begin
               ent_d[i].st     = (byp0 && byp1) ? ST_READY : ST_WAIT;
               ent_d[i].rdy0   = byp0;
               ent_d[i].rdy1   = byp1;
               ent_d[i].tag0   = alloc_tag0;
               ent_d[i].tag1   = alloc_tag1;
               ent_d[i].wb_tag = alloc_wb_tag;
               ent_d[i].instr  = alloc_instr;
               age_d[i]        = '0;
            end else if (occ[i]) begin
               // every occupied entry is older than the newcomer
               age_d[i] = age_q[i] | entry_write;
            end
         end
      end
   end

   // Entry, age-matrix and free-count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ent_q[i] <= ENTRY_RST;
            age_q[i] <= '0;
         end
         free_q <= CNT_W'(ENTRIES);
      end else begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ent_q[i] <= ent_d[i];
            age_q[i] <= age_d[i];
         end
         free_q <= free_d;
      end
   end

   // Output stage: load on selection, drain on accept, hold while stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_valid  <= 1'b0;
         issue_instr  <= '0;
         issue_wb_tag <= '0;
         issue_entry  <= '0;
      end else if (flush) begin
         issue_valid <= 1'b0;
      end else if (sel_fire) begin
         issue_valid  <= 1'b1;
         issue_instr  <= sel_ent.instr;
         issue_wb_tag <= sel_ent.wb_tag;
         issue_entry  <= sel_idx;
      end else if (issue_ready) begin
         issue_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Self-checking bench for rs_issue_sched: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_rs_issue_sched;

   localparam int unsigned ENT = 4;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [15:0] alloc_instr;
   logic [7:0]  alloc_wb_tag;
   logic [7:0]  alloc_tag0;
   logic [7:0]  alloc_tag1;
   logic        alloc_rdy0;
   logic        alloc_rdy1;
   logic        bcast_valid;
   logic [7:0]  bcast_tag;
   logic        issue_valid;
   logic        issue_ready;
   logic [15:0] issue_instr;
   logic [7:0]  issue_wb_tag;
   logic [1:0]  issue_entry;
   logic [3:0]  entry_write;
   logic [3:0]  entry_read;
   logic [2:0]  free_count;

   int n_checks = 0;
   int n_fail   = 0;

   rs_issue_sched #(.ENTRIES(4), .instr_width(16), .tag_width(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_instr(alloc_instr),
      .alloc_wb_tag(alloc_wb_tag), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
      .alloc_rdy0(alloc_rdy0), .alloc_rdy1(alloc_rdy1),
      .bcast_valid(bcast_valid), .bcast_tag(bcast_tag),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
      .issue_wb_tag(issue_wb_tag), .issue_entry(issue_entry),
      .entry_write(entry_write), .entry_read(entry_read), .free_count(free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: entries kept in allocation order (front = oldest)
   typedef struct {
      logic [15:0] instr;
      logic [7:0]  wb;
      logic [7:0]  t0;
      logic [7:0]  t1;
      bit          r0;
      bit          r1;
      int          idx;
   } m_ent_t;

   m_ent_t      mq[$];
   bit          m_iv;
   logic [15:0] m_instr;
   logic [7:0]  m_wb;
   int          m_entry;
   bit          m_afire;
   int          m_aidx;
   int          m_spos;
   bit          e_aready;
   logic [2:0]  e_free;
   logic [3:0]  e_write;
   logic [3:0]  e_read;

   task automatic model_reset();
      mq.delete();
      m_iv = 0; m_instr = '0; m_wb = '0; m_entry = 0;
   endtask

   task automatic model_eval();
      bit used [ENT];
      for (int k = 0; k < int'(ENT); k++) used[k] = 0;
      foreach (mq[p]) used[mq[p].idx] = 1;
      e_free   = 3'(int'(ENT) - mq.size());
      e_aready = (mq.size() < int'(ENT));
      m_afire  = alloc_valid && e_aready && !flush;
      m_aidx   = -1;
      for (int k = int'(ENT) - 1; k >= 0; k--) if (!used[k]) m_aidx = k;
      m_spos = -1;
      if (!flush && (!m_iv || issue_ready)) begin
         for (int p = 0; p < mq.size(); p++) begin
            if (mq[p].r0 && mq[p].r1) begin
               m_spos = p;
               break;
            end
         end
      end
      e_write = m_afire ? 4'(1 << m_aidx) : 4'b0;
      e_read  = (m_spos >= 0) ? 4'(1 << mq[m_spos].idx) : 4'b0;
   endtask

   task automatic model_commit();
      m_ent_t ne;
      if (flush) begin
         mq.delete();
         m_iv = 0;
      end else begin
         if (m_spos >= 0) begin
            m_iv = 1; m_instr = mq[m_spos].instr; m_wb = mq[m_spos].wb; m_entry = mq[m_spos].idx;
            mq.delete(m_spos);
         end else if (issue_ready) begin
            m_iv = 0;
         end
         foreach (mq[p]) begin
            if (bcast_valid && mq[p].t0 == bcast_tag) mq[p].r0 = 1;
            if (bcast_valid && mq[p].t1 == bcast_tag) mq[p].r1 = 1;
         end
         if (m_afire) begin
            ne.instr = alloc_instr; ne.wb = alloc_wb_tag; ne.t0 = alloc_tag0; ne.t1 = alloc_tag1;
            ne.r0 = alloc_rdy0 || (bcast_valid && alloc_tag0 == bcast_tag);
            ne.r1 = alloc_rdy1 || (bcast_valid && alloc_tag1 == bcast_tag);
            ne.idx = m_aidx;
            mq.push_back(ne);
         end
      end
   endtask

   task automatic idle();
      flush = 0; alloc_valid = 0; alloc_instr = '0; alloc_wb_tag = '0;
      alloc_tag0 = '0; alloc_tag1 = '0; alloc_rdy0 = 0; alloc_rdy1 = 0;
      bcast_valid = 0; bcast_tag = '0;
   endtask

   task automatic set_alloc(input logic [15:0] i, input logic [7:0] wb, input logic [7:0] t0,
                            input logic [7:0] t1, input logic r0, input logic r1);
      alloc_valid = 1; alloc_instr = i; alloc_wb_tag = wb;
      alloc_tag0 = t0; alloc_tag1 = t1; alloc_rdy0 = r0; alloc_rdy1 = r1;
   endtask

   task automatic next_cyc();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      idle(); issue_ready = 1;
      repeat (4) next_cyc();
   endtask

   task automatic test_reset();
      idle(); issue_ready = 0; rst = 1;
      #1 rst = 0;
      #1;
      n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset alloc_ready: got %b want 1", alloc_ready); end
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset issue_valid: got %b want 0", issue_valid); end
      n_checks++; if (issue_instr !== 16'h0) begin n_fail++; $display("FAIL reset issue_instr: got %h want 0000", issue_instr); end
      n_checks++; if (issue_wb_tag !== 8'h0) begin n_fail++; $display("FAIL reset issue_wb_tag: got %h want 00", issue_wb_tag); end
      n_checks++; if (issue_entry !== 2'd0) begin n_fail++; $display("FAIL reset issue_entry: got %0d want 0", issue_entry); end
      n_checks++; if (entry_write !== 4'b0) begin n_fail++; $display("FAIL reset entry_write: got %b want 0000", entry_write); end
      n_checks++; if (entry_read !== 4'b0) begin n_fail++; $display("FAIL reset entry_read: got %b want 0000", entry_read); end
      n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL reset free_count: got %0d want 4", free_count); end
      @(negedge clk); rst = 1;
      next_cyc();
   endtask

   task automatic test_ready_alloc();
      issue_ready = 1;
      set_alloc(16'h0011, 8'h05, 8'h00, 8'h00, 1, 1);
      @(negedge clk);
      n_checks++; if (entry_write !== 4'b0001) begin n_fail++; $display("FAIL ready_alloc write: got %b want 0001", entry_write); end
      next_cyc(); idle();
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0001) begin n_fail++; $display("FAIL ready_alloc read: got %b want 0001", entry_read); end
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL ready_alloc early valid: got %b want 0", issue_valid); end
      n_checks++; if (free_count !== 3'd3) begin n_fail++; $display("FAIL ready_alloc free t+1: got %0d want 3", free_count); end
      next_cyc();
      @(negedge clk);
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL ready_alloc valid t+2: got %b want 1", issue_valid); end
      n_checks++; if (issue_wb_tag !== 8'h05) begin n_fail++; $display("FAIL ready_alloc wb_tag: got %h want 05", issue_wb_tag); end
      n_checks++; if (issue_instr !== 16'h0011) begin n_fail++; $display("FAIL ready_alloc instr: got %h want 0011", issue_instr); end
      n_checks++; if (issue_entry !== 2'd0) begin n_fail++; $display("FAIL ready_alloc entry: got %0d want 0", issue_entry); end
      n_checks++; if (free_count !== 3'd4) begin n_fail++; $display("FAIL ready_alloc free t+2: got %0d want 4", free_count); end
      drain();
   endtask

   task automatic test_fill_wakeup();
      issue_ready = 1;
      for (int k = 0; k < 4; k++) begin
         set_alloc(16'(16'h0100 + k), 8'(8'h10 + k), 8'h20, 8'h00, 0, 1);
         @(negedge clk);
         n_checks++; if (entry_write !== 4'(1 << k)) begin n_fail++; $display("FAIL fill write %0d: got %b want %b", k, entry_write, 4'(1 << k)); end
         next_cyc();
      end
      idle(); bcast_valid = 1; bcast_tag = 8'h20;
      @(negedge clk);
      n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill alloc_ready: got %b want 0", alloc_ready); end
      n_checks++; if (free_count !== 3'd0) begin n_fail++; $display("FAIL fill free_count: got %0d want 0", free_count); end
      next_cyc(); idle();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++; if (entry_read !== ((k < 4) ? 4'(1 << k) : 4'b0)) begin n_fail++; $display("FAIL wake read %0d: got %b", k, entry_read); end
         if (k >= 1) begin
            n_checks++; if (issue_valid !== 1'b1 || issue_wb_tag !== 8'(8'h10 + k - 1) || issue_entry !== 2'(k - 1)) begin
               n_fail++; $display("FAIL wake issue %0d: got v=%b wb=%h e=%0d want v=1 wb=%h e=%0d", k, issue_valid, issue_wb_tag, issue_entry, 8'(8'h10 + k - 1), k - 1);
            end
         end
         if (k == 1) begin
            n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL wake alloc_ready: got %b want 1", alloc_ready); end
         end
         next_cyc();
      end
      drain();
   endtask

   task automatic test_age_order();
      issue_ready = 1;
      set_alloc(16'h0A00, 8'hA0, 8'h30, 8'h00, 0, 1); next_cyc();
      set_alloc(16'h0B00, 8'hB0, 8'h00, 8'h00, 1, 1); next_cyc();
      idle(); bcast_valid = 1; bcast_tag = 8'h30;
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0010) begin n_fail++; $display("FAIL age1 read B: got %b want 0010", entry_read); end
      next_cyc(); idle();
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0001 || issue_wb_tag !== 8'hB0) begin n_fail++; $display("FAIL age1 B first: got rd=%b wb=%h want rd=0001 wb=b0", entry_read, issue_wb_tag); end
      next_cyc();
      @(negedge clk);
      n_checks++; if (issue_valid !== 1'b1 || issue_wb_tag !== 8'hA0) begin n_fail++; $display("FAIL age1 A next: got v=%b wb=%h want v=1 wb=a0", issue_valid, issue_wb_tag); end
      drain();
      // younger entry lands at a lower index than the older one
      issue_ready = 0;
      set_alloc(16'h0C00, 8'hC0, 8'h00, 8'h00, 1, 1); next_cyc();
      set_alloc(16'h0C01, 8'hC1, 8'h31, 8'h00, 0, 1);
      @(negedge clk);
      n_checks++; if (entry_write !== 4'b0010) begin n_fail++; $display("FAIL age2 write Y: got %b want 0010", entry_write); end
      next_cyc();
      set_alloc(16'h0C02, 8'hC2, 8'h00, 8'h00, 1, 1);
      @(negedge clk);
      n_checks++; if (entry_write !== 4'b0001) begin n_fail++; $display("FAIL age2 write Z: got %b want 0001", entry_write); end
      next_cyc();
      idle(); bcast_valid = 1; bcast_tag = 8'h31; next_cyc();
      idle();
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0000 || issue_wb_tag !== 8'hC0) begin n_fail++; $display("FAIL age2 blocked: got rd=%b wb=%h want rd=0000 wb=c0", entry_read, issue_wb_tag); end
      next_cyc(); issue_ready = 1;
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0010) begin n_fail++; $display("FAIL age2 older first: got %b want 0010", entry_read); end
      next_cyc();
      @(negedge clk);
      n_checks++; if (issue_wb_tag !== 8'hC1 || issue_entry !== 2'd1 || entry_read !== 4'b0001) begin n_fail++; $display("FAIL age2 Y issue: got wb=%h e=%0d rd=%b want c1 1 0001", issue_wb_tag, issue_entry, entry_read); end
      next_cyc();
      @(negedge clk);
      n_checks++; if (issue_wb_tag !== 8'hC2 || issue_entry !== 2'd0) begin n_fail++; $display("FAIL age2 Z issue: got wb=%h e=%0d want c2 0", issue_wb_tag, issue_entry); end
      drain();
   endtask

   task automatic test_bypass();
      issue_ready = 1;
      set_alloc(16'h0041, 8'h55, 8'h00, 8'h41, 1, 0);
      bcast_valid = 1; bcast_tag = 8'h41;
      @(negedge clk);
      n_checks++; if (entry_write !== 4'b0001) begin n_fail++; $display("FAIL bypass write: got %b want 0001", entry_write); end
      next_cyc(); idle();
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0001) begin n_fail++; $display("FAIL bypass read t+1: got %b want 0001", entry_read); end
      next_cyc();
      @(negedge clk);
      n_checks++; if (issue_valid !== 1'b1 || issue_wb_tag !== 8'h55) begin n_fail++; $display("FAIL bypass issue t+2: got v=%b wb=%h want v=1 wb=55", issue_valid, issue_wb_tag); end
      drain();
   endtask

   task automatic test_stall();
      issue_ready = 0;
      set_alloc(16'h0061, 8'h61, 8'h00, 8'h00, 1, 1); next_cyc();
      set_alloc(16'h0062, 8'h62, 8'h00, 8'h00, 1, 1);
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0001) begin n_fail++; $display("FAIL stall first read: got %b want 0001", entry_read); end
      next_cyc(); idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++; if (issue_valid !== 1'b1 || issue_wb_tag !== 8'h61 || issue_instr !== 16'h0061 || issue_entry !== 2'd0 || entry_read !== 4'b0) begin
            n_fail++; $display("FAIL stall hold %0d: got v=%b wb=%h i=%h e=%0d rd=%b", k, issue_valid, issue_wb_tag, issue_instr, issue_entry, entry_read);
         end
         next_cyc();
      end
      issue_ready = 1;
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0010 || issue_wb_tag !== 8'h61) begin n_fail++; $display("FAIL stall drain: got rd=%b wb=%h want 0010 61", entry_read, issue_wb_tag); end
      next_cyc();
      @(negedge clk);
      n_checks++; if (issue_valid !== 1'b1 || issue_wb_tag !== 8'h62) begin n_fail++; $display("FAIL stall second: got v=%b wb=%h want 1 62", issue_valid, issue_wb_tag); end
      next_cyc();
      @(negedge clk);
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL stall empty: got %b want 0", issue_valid); end
      drain();
   endtask

   task automatic test_flush();
      issue_ready = 0;
      for (int k = 0; k < 4; k++) begin
         set_alloc(16'(16'h0070 + k), 8'(8'h70 + k), 8'h00, 8'h00, 1, 1);
         next_cyc();
      end
      idle();
      @(negedge clk);
      n_checks++; if (free_count !== 3'd1 || issue_valid !== 1'b1) begin n_fail++; $display("FAIL flush pre: got free=%0d v=%b want 1 1", free_count, issue_valid); end
      next_cyc();
      flush = 1; issue_ready = 1; bcast_valid = 1; bcast_tag = 8'h00;
      set_alloc(16'h0077, 8'h77, 8'h00, 8'h00, 1, 1);
      @(negedge clk);
      n_checks++; if (entry_write !== 4'b0 || entry_read !== 4'b0) begin n_fail++; $display("FAIL flush strobes: got wr=%b rd=%b want 0000 0000", entry_write, entry_read); end
      next_cyc(); idle();
      @(negedge clk);
      n_checks++; if (free_count !== 3'd4 || issue_valid !== 1'b0 || alloc_ready !== 1'b1 || entry_read !== 4'b0) begin
         n_fail++; $display("FAIL flush post: got free=%0d v=%b ar=%b rd=%b want 4 0 1 0000", free_count, issue_valid, alloc_ready, entry_read);
      end
      drain();
   endtask

   task automatic test_async_reset();
      issue_ready = 0;
      set_alloc(16'h0099, 8'h99, 8'h00, 8'h00, 1, 1); next_cyc();
      set_alloc(16'h009A, 8'h9A, 8'h00, 8'h00, 1, 1); next_cyc();
      idle();
      @(negedge clk);
      n_checks++; if (issue_valid !== 1'b1 || free_count !== 3'd3) begin n_fail++; $display("FAIL areset pre: got v=%b free=%0d want 1 3", issue_valid, free_count); end
      #2 rst = 0;
      #1;
      n_checks++; if (issue_valid !== 1'b0 || issue_wb_tag !== 8'h0 || issue_instr !== 16'h0 || issue_entry !== 2'd0 || free_count !== 3'd4 || alloc_ready !== 1'b1) begin
         n_fail++; $display("FAIL areset values: got v=%b wb=%h i=%h e=%0d free=%0d ar=%b", issue_valid, issue_wb_tag, issue_instr, issue_entry, free_count, alloc_ready);
      end
      @(posedge clk); #3 rst = 1;
      issue_ready = 1;
      set_alloc(16'h00AB, 8'hAB, 8'h00, 8'h00, 1, 1);
      #1;
      n_checks++; if (entry_write !== 4'b0001) begin n_fail++; $display("FAIL areset first write: got %b want 0001", entry_write); end
      next_cyc(); idle();
      @(negedge clk);
      n_checks++; if (entry_read !== 4'b0001) begin n_fail++; $display("FAIL areset first select: got %b want 0001", entry_read); end
      drain();
   endtask

   task automatic test_random();
      idle(); issue_ready = 0;
      rst = 0; model_reset();
      @(negedge clk); rst = 1;
      next_cyc();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         alloc_valid  = ($urandom_range(0, 99) < 60);
         alloc_instr  = 16'($urandom);
         alloc_wb_tag = 8'($urandom);
         alloc_tag0   = 8'($urandom_range(0, 7));
         alloc_tag1   = 8'($urandom_range(0, 7));
         alloc_rdy0   = 1'($urandom_range(0, 1));
         alloc_rdy1   = 1'($urandom_range(0, 1));
         bcast_valid  = ($urandom_range(0, 99) < 50);
         bcast_tag    = 8'($urandom_range(0, 7));
         issue_ready  = ($urandom_range(0, 99) < 70);
         flush        = ($urandom_range(0, 99) < 2);
         @(negedge clk);
         model_eval();
         n_checks++;
         if ({alloc_ready, free_count, entry_write, entry_read, issue_valid} !== {e_aready, e_free, e_write, e_read, m_iv}) begin
            n_fail++;
            $display("FAIL rnd ctrl cyc %0d: got ar=%b free=%0d wr=%b rd=%b v=%b want ar=%b free=%0d wr=%b rd=%b v=%b",
                     cyc, alloc_ready, free_count, entry_write, entry_read, issue_valid, e_aready, e_free, e_write, e_read, m_iv);
         end
         if (m_iv) begin
            n_checks++;
            if ({issue_instr, issue_wb_tag, issue_entry} !== {m_instr, m_wb, 2'(m_entry)}) begin
               n_fail++;
               $display("FAIL rnd data cyc %0d: got i=%h wb=%h e=%0d want i=%h wb=%h e=%0d",
                        cyc, issue_instr, issue_wb_tag, issue_entry, m_instr, m_wb, m_entry);
            end
         end
         @(posedge clk);
         model_commit();
         #1;
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_ready_alloc();
      test_fill_wakeup();
      test_age_order();
      test_bypass();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
